// File: rtl/cvxif_copro_exec.sv
// cvxif_copro_exec
//   Execution stage of the CV-X-IF example coprocessor. Accepted offloaded
//   instructions are queued with their operands and executed in order on one
//   multi-cycle unit. Every accepted instruction returns exactly one result
//   on the valid/ready result channel.
//
// Ports
//   clk_i, rst_ni         clock (rising edge), asynchronous active-low reset
//   flush_i               synchronous kill of queued and in-flight work
//   issue_valid_i/ready_o issue handshake from the decoder
//   issue_instr_i         instruction word (opcode [6:0], rd [11:7])
//   issue_rs1_i/rs2_i     source operands
//   issue_id_i, issue_we_i instruction id and writeback flag
//   result_valid_o/ready_i result handshake to the core
//   result_id_o, result_data_o, result_rd_o, result_we_o registered result

module cvxif_copro_exec #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned Depth  = 4,
  parameter int unsigned IdBits = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              issue_valid_i,
  output logic              issue_ready_o,
  input  logic [31:0]       issue_instr_i,
  input  logic [XLEN-1:0]   issue_rs1_i,
  input  logic [XLEN-1:0]   issue_rs2_i,
  input  logic [IdBits-1:0] issue_id_i,
  input  logic              issue_we_i,
  output logic              result_valid_o,
  input  logic              result_ready_i,
  output logic [IdBits-1:0] result_id_o,
  output logic [XLEN-1:0]   result_data_o,
  output logic [4:0]        result_rd_o,
  output logic              result_we_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned SW = $clog2(XLEN);
  localparam int unsigned CW = $clog2(XLEN + 2);

  typedef enum logic [1:0] {IDLE, EXEC, RESULT} state_t;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_ROL, OP_MUL, OP_NONE} op_t;

  // ---------------------------------------------------------------- queue
  logic [6:0]        q_opc [Depth];
  logic [4:0]        q_rd  [Depth];
  logic [XLEN-1:0]   q_rs1 [Depth];
  logic [XLEN-1:0]   q_rs2 [Depth];
  logic [IdBits-1:0] q_id  [Depth];
  logic              q_we  [Depth];

  logic [PW-1:0] wptr_q, rptr_q;
  logic [AW-1:0] waddr, raddr;
  logic          full, empty, push, pop;

  // only opcode and rd are needed from the instruction word
  logic unused_instr_hi;
  assign unused_instr_hi = ^issue_instr_i[31:12];

  assign waddr = wptr_q[AW-1:0];
  assign raddr = rptr_q[AW-1:0];
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PW-1] != rptr_q[PW-1]) && (waddr == raddr);

  assign issue_ready_o = !full && !flush_i;
  assign push          = issue_valid_i && issue_ready_o;

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_opc[waddr] <= issue_instr_i[6:0];
      q_rd[waddr]  <= issue_instr_i[11:7];
      q_rs1[waddr] <= issue_rs1_i;
      q_rs2[waddr] <= issue_rs2_i;
      q_id[waddr]  <= issue_id_i;
      q_we[waddr]  <= issue_we_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
    end
  end

  // --------------------------------------------------------- head decode
  // Counter is loaded with EXEC cycles + 1: the last EXEC cycle (count==1)
  // is spent registering the result, the ones before it do the work.
  op_t           head_op;
  logic [CW-1:0] head_lat;

  always_comb begin
    head_op  = OP_NONE;
    head_lat = CW'(2);
    case (q_opc[raddr])
      7'b0001011: begin head_op = OP_ADD; head_lat = CW'(2);        end
      7'b0101011: begin head_op = OP_SUB; head_lat = CW'(2);        end
      7'b1011011: begin head_op = OP_ROL; head_lat = CW'(3);        end
      7'b1111011: begin head_op = OP_MUL; head_lat = CW'(XLEN + 1); end
      default:    ;
    endcase
  end

  // ------------------------------------------------------------------ FSM
  state_t state_q, state_d;
  logic   finish;

  logic [CW-1:0]     cnt_q;
  op_t               op_q;
  logic [XLEN-1:0]   opa_q, opb_q, acc_q;
  logic [IdBits-1:0] cur_id_q;
  logic [4:0]        cur_rd_q;
  logic              cur_we_q;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == CW'(1)) begin
          finish  = 1'b1;
          state_d = RESULT;
        end
      end
      RESULT: begin
        if (result_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d = IDLE;
      pop     = 1'b0;
      finish  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // ------------------------------------------------------------- datapath
  logic [2*XLEN-1:0] rot_dbl;
  logic [XLEN-1:0]   exec_result;

  always_comb begin
    rot_dbl = {opa_q, opa_q} << opb_q[SW-1:0];
    case (op_q)
      OP_ADD:  exec_result = opa_q + opb_q;
      OP_SUB:  exec_result = opa_q - opb_q;
      OP_ROL:  exec_result = rot_dbl[2*XLEN-1:XLEN];
      OP_MUL:  exec_result = acc_q;
      default: exec_result = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q          <= '0;
      op_q           <= OP_NONE;
      opa_q          <= '0;
      opb_q          <= '0;
      acc_q          <= '0;
      cur_id_q       <= '0;
      cur_rd_q       <= '0;
      cur_we_q       <= 1'b0;
      result_valid_o <= 1'b0;
      result_id_o    <= '0;
      result_data_o  <= '0;
      result_rd_o    <= '0;
      result_we_o    <= 1'b0;
    end else begin
      if (pop) begin
        op_q     <= head_op;
        opa_q    <= q_rs1[raddr];
        opb_q    <= q_rs2[raddr];
        acc_q    <= '0;
        cnt_q    <= head_lat;
        cur_id_q <= q_id[raddr];
        cur_rd_q <= q_rd[raddr];
        cur_we_q <= q_we[raddr] && (head_op != OP_NONE);
      end else if (state_q == EXEC && !flush_i) begin
        cnt_q <= cnt_q - CW'(1);
        if (!finish && op_q == OP_MUL) begin
          if (opb_q[0]) acc_q <= acc_q + opa_q;
          opa_q <= opa_q << 1;
          opb_q <= opb_q >> 1;
        end
      end

      if (finish) begin
        result_valid_o <= 1'b1;
        result_data_o  <= exec_result;
        result_id_o    <= cur_id_q;
        result_rd_o    <= cur_rd_q;
        result_we_o    <= cur_we_q;
      end else if (flush_i || (state_q == RESULT && result_ready_i)) begin
        result_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cvxif_copro_exec.sv
// tb_cvxif_copro_exec
//   Directed and randomized checks of cvxif_copro_exec against a behavioural
//   model (plain arithmetic per opcode plus an in-order expected-result queue).

module tb_cvxif_copro_exec;

  logic        clk, rst_n, flush, issue_valid, result_ready;
  logic [31:0] instr, rs1, rs2;
  logic [2:0]  id;
  logic        we;
  logic        issue_ready_o, result_valid_o, result_we_o;
  logic [2:0]  result_id_o;
  logic [31:0] result_data_o;
  logic [4:0]  result_rd_o;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  id;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    int          lat;
  } exp_t;

  exp_t sb[$];

  cvxif_copro_exec #(.XLEN(32), .Depth(4), .IdBits(3)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush),
    .issue_valid_i  (issue_valid),
    .issue_ready_o  (issue_ready_o),
    .issue_instr_i  (instr),
    .issue_rs1_i    (rs1),
    .issue_rs2_i    (rs2),
    .issue_id_i     (id),
    .issue_we_i     (we),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready),
    .result_id_o    (result_id_o),
    .result_data_o  (result_data_o),
    .result_rd_o    (result_rd_o),
    .result_we_o    (result_we_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  // ------------------------------------------------------------ model
  function automatic logic ref_known(input logic [6:0] opc);
    return opc == 7'h0B || opc == 7'h2B || opc == 7'h5B || opc == 7'h7B;
  endfunction

  function automatic logic [31:0] ref_data(input logic [6:0] opc,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] t;
    case (opc)
      7'h0B: return a + b;
      7'h2B: return a - b;
      7'h5B: begin t = {32'd0, a} << (b % 32); return t[31:0] | t[63:32]; end
      7'h7B: begin t = {32'd0, a} * {32'd0, b}; return t[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [6:0] opc);
    case (opc)
      7'h5B:   return 2;
      7'h7B:   return 32;
      default: return 1;
    endcase
  endfunction

  function automatic exp_t make_exp(input logic [31:0] word, input logic [31:0] a,
                                    input logic [31:0] b, input logic [2:0] i,
                                    input logic w);
    exp_t e;
    e.id   = i;
    e.data = ref_data(word[6:0], a, b);
    e.rd   = word[11:7];
    e.we   = w && ref_known(word[6:0]);
    e.lat  = ref_lat(word[6:0]);
    return e;
  endfunction

  // ------------------------------------------------------------ helpers
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_front(input string tag);
    if (sb.size() == 0) begin
      chk({tag, "_unexpected_valid"}, result_valid_o, 0);
    end else begin
      chk({tag, "_id"},   result_id_o,   sb[0].id);
      chk({tag, "_data"}, result_data_o, sb[0].data);
      chk({tag, "_rd"},   result_rd_o,   sb[0].rd);
      chk({tag, "_we"},   result_we_o,   sb[0].we);
    end
  endtask

  // call at a negedge; returns the edge number of the issue handshake
  task automatic send(input logic [6:0] opc, input logic [4:0] rd,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] i, input logic w, output int n);
    logic [31:0] word;
    int g;
    word       = $urandom();
    word[11:7] = rd;
    word[6:0]  = opc;
    instr = word; rs1 = a; rs2 = b; id = i; we = w;
    issue_valid = 1'b1;
    g = 0;
    while (!issue_ready_o && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) chk("issue_accept", issue_ready_o, 1);
    sb.push_back(make_exp(word, a, b, i, w));
    @(negedge clk);
    n = cyc;
    issue_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int at);
    int g;
    g = 0;
    while (!result_valid_o && g < budget) begin
      @(negedge clk);
      g++;
    end
    at = cyc;
    chk("result_valid_arrives", result_valid_o, 1);
  endtask

  task automatic take_one(input string tag);
    chk_front(tag);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    if (sb.size() > 0) void'(sb.pop_front());
  endtask

  task automatic drain(input int budget);
    int g, prev;
    g = 0;
    prev = -1;
    result_ready = 1'b1;
    while (sb.size() > 0 && g < budget) begin
      if (result_valid_o) begin
        if (prev >= 0) chk("drain_spacing", cyc - prev, 3 + sb[0].lat);
        prev = cyc;
        chk_front("drain");
        void'(sb.pop_front());
      end
      @(negedge clk);
      g++;
    end
    result_ready = 1'b0;
    chk("drain_left", sb.size(), 0);
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    int n, n2, at, sent, g;
    logic seen;
    logic [31:0] word;
    logic [6:0] opcs [5];
    exp_t e;

    opcs = '{7'h0B, 7'h2B, 7'h5B, 7'h7B, 7'h33};
    rst_n = 1'b0; flush = 1'b0; issue_valid = 1'b0; result_ready = 1'b0;
    instr = '0; rs1 = '0; rs2 = '0; id = '0; we = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_issue_ready", issue_ready_o, 1);
    chk("rst_valid", result_valid_o, 0);
    chk("rst_id", result_id_o, 0);
    chk("rst_data", result_data_o, 0);
    chk("rst_rd", result_rd_o, 0);
    chk("rst_we", result_we_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // custom0: 5 + 7
    send(7'h0B, 5'd3, 32'd5, 32'd7, 3'd2, 1'b1, n);
    wait_valid(100, at);
    chk("c0_latency", at - n, 3);
    chk("c0_data", result_data_o, 32'd12);
    chk("c0_id", result_id_o, 3'd2);
    chk("c0_rd", result_rd_o, 5'd3);
    chk("c0_we", result_we_o, 1);
    take_one("c0");

    // custom3: 0xFFFFFFFF * 3
    send(7'h7B, 5'd9, 32'hFFFF_FFFF, 32'd3, 3'd5, 1'b1, n);
    wait_valid(100, at);
    chk("c3_latency", at - n, 34);
    chk("c3_data", result_data_o, 32'hFFFF_FFFD);
    take_one("c3");

    // custom2: rotate by 36 (uses low 5 bits = 4)
    send(7'h5B, 5'd17, 32'h8000_0001, 32'd36, 3'd1, 1'b1, n);
    wait_valid(100, at);
    chk("c2_latency", at - n, 4);
    chk("c2_data", result_data_o, 32'h0000_0018);
    take_one("c2");

    // fill: one entry in the unit plus Depth queued
    for (int i = 0; i < 5; i++) begin
      chk("fill_ready", issue_ready_o, 1);
      send(7'h2B, 5'($urandom()), $urandom(), $urandom(), 3'(i), 1'b1, n);
    end
    chk("full_ready_low", issue_ready_o, 0);
    wait_valid(50, at);
    for (int i = 0; i < 5; i++) begin
      chk_front("hold");
      chk("hold_ready_low", issue_ready_o, 0);
      @(negedge clk);
    end
    take_one("head0");
    chk("ready_low_before_pop", issue_ready_o, 0);
    @(negedge clk);
    chk("ready_back_after_pop", issue_ready_o, 1);
    drain(200);

    // unknown opcode still produces a result, next instruction still runs
    send(7'h33, 5'd4, $urandom(), $urandom(), 3'd6, 1'b1, n);
    send(7'h0B, 5'd8, $urandom(), $urandom(), 3'd7, 1'b1, n2);
    wait_valid(50, at);
    chk("unk_data", result_data_o, 0);
    chk("unk_we", result_we_o, 0);
    drain(100);

    // flush while custom3 executes with two entries queued
    result_ready = 1'b1;
    send(7'h7B, 5'd1, $urandom(), $urandom(), 3'd0, 1'b1, n);
    send(7'h0B, 5'd2, $urandom(), $urandom(), 3'd1, 1'b1, n2);
    send(7'h0B, 5'd3, $urandom(), $urandom(), 3'd2, 1'b1, n2);
    while (cyc < n + 6) @(negedge clk);
    flush = 1'b1;
    issue_valid = 1'b1;
    instr = 32'h0000_008B; rs1 = 32'd1; rs2 = 32'd1; id = 3'd3; we = 1'b1;
    #1;
    chk("flush_ready_low", issue_ready_o, 0);
    @(negedge clk);
    flush = 1'b0;
    issue_valid = 1'b0;
    sb.delete();
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (result_valid_o) seen = 1'b1;
    end
    chk("no_result_after_flush", seen, 0);
    result_ready = 1'b0;
    send(7'h0B, 5'd6, 32'd100, 32'd23, 3'd4, 1'b0, n);
    wait_valid(50, at);
    chk("post_flush_latency", at - n, 3);
    chk("post_flush_data", result_data_o, 32'd123);
    take_one("post_flush");

    // asynchronous reset while a result is pending and entries are queued
    send(7'h0B, 5'd10, $urandom(), $urandom(), 3'd1, 1'b1, n);
    send(7'h2B, 5'd11, $urandom(), $urandom(), 3'd2, 1'b1, n2);
    send(7'h0B, 5'd12, $urandom(), $urandom(), 3'd3, 1'b1, n2);
    wait_valid(50, at);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", result_valid_o, 0);
    chk("arst_id", result_id_o, 0);
    chk("arst_data", result_data_o, 0);
    chk("arst_rd", result_rd_o, 0);
    chk("arst_we", result_we_o, 0);
    chk("arst_issue_ready", issue_ready_o, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    seen = 1'b0;
    result_ready = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (result_valid_o) seen = 1'b1;
    end
    result_ready = 1'b0;
    chk("no_stale_after_reset", seen, 0);
    send(7'h0B, 5'd13, 32'd40, 32'd2, 3'd5, 1'b1, n);
    wait_valid(50, at);
    chk("post_reset_latency", at - n, 3);
    chk("post_reset_id", result_id_o, 3'd5);
    take_one("post_reset");

    // randomized traffic with random backpressure
    sent = 0;
    g = 0;
    while ((sent < 40 || sb.size() > 0) && g < 6000) begin
      result_ready = ($urandom_range(0, 3) != 0);
      if (result_valid_o) begin
        chk_front("rnd");
        if (result_ready && sb.size() > 0) void'(sb.pop_front());
      end
      if (sent < 40 && $urandom_range(0, 1) == 1) begin
        word = $urandom();
        word[6:0] = opcs[$urandom_range(0, 4)];
        instr = word;
        rs1 = $urandom();
        rs2 = $urandom();
        id = 3'($urandom());
        we = 1'($urandom());
        issue_valid = 1'b1;
        if (issue_ready_o) begin
          e = make_exp(word, rs1, rs2, id, we);
          sb.push_back(e);
          sent++;
        end
      end else begin
        issue_valid = 1'b0;
      end
      @(negedge clk);
      g++;
    end
    issue_valid = 1'b0;
    result_ready = 1'b0;
    chk("rnd_outstanding", sb.size(), 0);
    chk("rnd_sent", sent, 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
